// File: rtl/time_keeper.sv
// time_keeper -- timekeeping front end of the clock display path.
//
// Divides the system clock into a one-second tick, keeps hours/minutes/seconds,
// lets the user set hours and minutes with two debounced push-buttons, and
// produces the digit-scan phase for the segment driver.
//
// Ports:
//   clock       in   1  system clock, all state on the rising edge
//   reset       in   1  asynchronous, active-low; clears every register
//   btn_mode    in   1  asynchronous button, active-high; cycles the set mode
//   btn_inc     in   1  asynchronous button, active-high; bumps the field being set
//   disp_sel    in   1  0 = HH:MM, 1 = MM:SS (used only in RUN)
//   data_show   out 12  {high field, low field}, each binary 0..59, registered
//   byte_status out  3  digit-scan phase 0..7, registered
//   set_mode    out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, registered
module time_keeper #(
  parameter int DIV      = 12_000_000,
  parameter int SCAN_DIV = 12_000,
  parameter int DEBOUNCE = 120_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        disp_sel,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [1:0]  set_mode
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_BAD      = 2'd3
  } state_e;

  // Button vectors: bit 0 = mode, bit 1 = inc.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         level_q, level_d;
  logic [1:0]         prev_q, prev_d;
  logic [1:0]         press_q, press_d;
  logic [1:0]         armed_q, armed_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  // Becomes all-ones once the synchronizers hold real samples after reset.
  logic [1:0]         vld_q, vld_d;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [5:0]         sec_q, sec_d;
  logic [5:0]         min_q, min_d;
  logic [4:0]         hour_q, hour_d;
  logic [11:0]        data_show_q, data_show_d;
  logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [2:0]         byte_status_q, byte_status_d;
  logic               tick_s;

  // Button synchronizers, debounce counters and press-pulse generation.
  always_comb begin
    sync1_d   = {btn_inc, btn_mode};
    sync2_d   = sync1_q;
    vld_d     = {vld_q[0], 1'b1};
    prev_d    = level_q;
    level_d   = level_q;
    armed_d   = armed_q;
    press_d   = 2'b00;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      // Count only while the synchronized level disagrees with the accepted one.
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i]   = sync2_q[i];
          deb_cnt_d[i] = {DW{1'b0}};
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end else begin
        deb_cnt_d[i] = {DW{1'b0}};
      end
      // A button held through reset release must be seen low before it may
      // produce a press; the valid pipe keeps reset-value zeros from arming it.
      if (vld_q[1] && !sync2_q[i]) begin
        armed_d[i] = 1'b1;
      end else begin
        armed_d[i] = armed_q[i];
      end
      press_d[i] = armed_q[i] & level_q[i] & ~prev_q[i];
    end
  end

  // Prescaler, time counters, set-mode state machine, display mux and scan.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    sec_d         = sec_q;
    min_d         = min_q;
    hour_d        = hour_q;
    data_show_d   = data_show_q;
    scan_cnt_d    = scan_cnt_q;
    byte_status_d = byte_status_q;

    tick_s = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // Prescaler is held at zero in any set mode so RUN restarts a full second.
    if (state_q != ST_RUN) begin
      presc_d = {PW{1'b0}};
    end else if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (tick_s) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      sec_d = sec_q;
    end

    // Mode press wins over an inc press arriving in the same cycle.
    case (state_q)
      ST_RUN: begin
        if (press_q[0]) begin
          state_d = ST_SET_HOUR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_HOUR: begin
        if (press_q[0]) begin
          state_d = ST_SET_MIN;
        end else if (press_q[1]) begin
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_MIN: begin
        if (press_q[0]) begin
          state_d = ST_RUN;
          sec_d   = 6'd0;
        end else if (press_q[1]) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end else begin
          state_d = ST_SET_MIN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Set modes always show HH:MM so the field being edited stays visible.
    case (state_q)
      ST_RUN: begin
        if (disp_sel) begin
          data_show_d = {min_q, sec_q};
        end else begin
          data_show_d = {1'b0, hour_q, min_q};
        end
      end
      default: begin
        data_show_d = {1'b0, hour_q, min_q};
      end
    endcase

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d    = {SW{1'b0}};
      byte_status_d = byte_status_q + 3'd1;
    end else begin
      scan_cnt_d    = scan_cnt_q + SW'(1);
      byte_status_d = byte_status_q;
    end
  end

  // All state registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 2'b00;
      sync2_q       <= 2'b00;
      level_q       <= 2'b00;
      prev_q        <= 2'b00;
      press_q       <= 2'b00;
      armed_q       <= 2'b00;
      deb_cnt_q     <= {(2 * DW){1'b0}};
      vld_q         <= 2'b00;
      state_q       <= ST_RUN;
      presc_q       <= {PW{1'b0}};
      sec_q         <= 6'd0;
      min_q         <= 6'd0;
      hour_q        <= 5'd0;
      data_show_q   <= 12'd0;
      scan_cnt_q    <= {SW{1'b0}};
      byte_status_q <= 3'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      level_q       <= level_d;
      prev_q        <= prev_d;
      press_q       <= press_d;
      armed_q       <= armed_d;
      deb_cnt_q     <= deb_cnt_d;
      vld_q         <= vld_d;
      state_q       <= state_d;
      presc_q       <= presc_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      data_show_q   <= data_show_d;
      scan_cnt_q    <= scan_cnt_d;
      byte_status_q <= byte_status_d;
    end
  end

  assign data_show   = data_show_q;
  assign byte_status = byte_status_q;
  assign set_mode    = state_q;

endmodule
